// File: rtl/hex_keypad_scanner_pkg.sv
// Shared types for the hex keypad scanner: scan-result encoding,
// debounce FSM states and small bit-vector helpers.
package hex_keypad_scanner_pkg;

    typedef enum logic [1:0] {
        RES_NONE  = 2'd0,
        RES_KEY   = 2'd1,
        RES_MULTI = 2'd2
    } res_tag_e;

    typedef struct packed {
        res_tag_e   tag;
        logic [3:0] code;
    } scan_result_t;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_PRESSED = 1'b1
    } state_e;

    localparam logic [3:0] COL_RESET = 4'b1110;

    localparam scan_result_t RESULT_NONE = '{tag: RES_NONE, code: 4'h0};

    // Index of the lowest zero bit; 0 when the vector has no zero.
    function automatic logic [1:0] low_index(input logic [3:0] v);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!v[i]) begin
                idx = 2'(i);
            end
        end
        return idx;
    endfunction

    function automatic logic [2:0] low_count(input logic [3:0] v);
        logic [2:0] n;
        n = 3'd0;
        for (int i = 0; i < 4; i++) begin
            n = n + {2'b00, ~v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/hex_keypad_scanner_col_scanner.sv
// Column driver, row synchroniser and per-scan key accumulator.
// Emits one scan result per full rotation of the four columns.
module keypad_col_scanner
    import hex_keypad_scanner_pkg::*;
#(
    parameter int SCAN_DIV = 50000
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [3:0]   row_in,
    output logic [3:0]   col_out,
    output logic         scan_done,
    output scan_result_t scan_result
);

    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] DWELL_LAST = CW'(SCAN_DIV - 1);

    logic [3:0]    row_meta;
    logic [3:0]    row_sync;
    logic [CW-1:0] dwell;
    logic [1:0]    seen;
    logic [3:0]    first_code;

    logic          sample;
    logic          last_col;
    logic [2:0]    row_lows;
    logic [1:0]    row_idx;
    logic [1:0]    col_idx;
    logic [2:0]    total;
    logic [3:0]    merged_code;

    assign sample      = (dwell == DWELL_LAST);
    assign last_col    = (col_out == 4'b0111);
    assign row_lows    = low_count(row_sync);
    assign row_idx     = low_index(row_sync);
    assign col_idx     = low_index(col_out);
    assign total       = {1'b0, seen} + row_lows;
    assign merged_code = (seen == 2'd0) ? {row_idx, col_idx} : first_code;
    assign scan_done   = sample && last_col;

    // Result includes the column being sampled right now, so the
    // consumer can act on the same edge that closes the scan.
    always_comb begin
        scan_result = RESULT_NONE;
        if (total == 3'd1) begin
            scan_result.tag  = RES_KEY;
            scan_result.code = merged_code;
        end else if (total >= 3'd2) begin
            scan_result.tag  = RES_MULTI;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_meta   <= 4'hF;
            row_sync   <= 4'hF;
            dwell      <= '0;
            col_out    <= COL_RESET;
            seen       <= 2'd0;
            first_code <= 4'h0;
        end else begin
            row_meta <= row_in;
            row_sync <= row_meta;
            if (sample) begin
                dwell   <= '0;
                col_out <= {col_out[2:0], col_out[3]};
                if (last_col) begin
                    seen       <= 2'd0;
                    first_code <= 4'h0;
                end else begin
                    if (seen == 2'd0 && row_lows != 3'd0) begin
                        first_code <= merged_code;
                    end
                    seen <= (total >= 3'd2) ? 2'd2 : total[1:0];
                end
            end else begin
                dwell <= dwell + CW'(1);
            end
        end
    end

endmodule

// File: rtl/hex_keypad_scanner.sv
// 4x4 keypad front end: debounces full-scan results, emits one code
// per accepted press and shifts codes into a two-digit byte.
module hex_keypad_scanner
    import hex_keypad_scanner_pkg::*;
#(
    parameter int SCAN_DIV       = 50000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] row_in,
    output logic [3:0] col_out,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held,
    input  logic       byte_clr,
    output logic [7:0] byte_out
);

    localparam logic [3:0] DB_MAX = 4'(DEBOUNCE_SCANS);

    scan_result_t scan_result;
    scan_result_t prev_result;
    logic         scan_done;
    logic [3:0]   stab_cnt;
    logic [3:0]   stab_next;
    logic         stable;
    state_e       state;

    keypad_col_scanner #(
        .SCAN_DIV(SCAN_DIV)
    ) u_scan (
        .clk        (clk),
        .rst_n      (rst_n),
        .row_in     (row_in),
        .col_out    (col_out),
        .scan_done  (scan_done),
        .scan_result(scan_result)
    );

    always_comb begin
        stab_next = 4'd1;
        if (scan_result == prev_result) begin
            stab_next = (stab_cnt >= DB_MAX) ? DB_MAX : stab_cnt + 4'd1;
        end
    end

    assign stable = (stab_next == DB_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stab_cnt    <= 4'd0;
            prev_result <= RESULT_NONE;
        end else if (scan_done) begin
            stab_cnt    <= stab_next;
            prev_result <= scan_result;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            key_code  <= 4'h0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
        end else begin
            key_valid <= 1'b0;
            if (scan_done && stable) begin
                unique case (state)
                    ST_IDLE: begin
                        if (scan_result.tag == RES_KEY) begin
                            key_code  <= scan_result.code;
                            key_valid <= 1'b1;
                            key_held  <= 1'b1;
                            state     <= ST_PRESSED;
                        end
                    end
                    ST_PRESSED: begin
                        if (scan_result.tag == RES_NONE) begin
                            key_held <= 1'b0;
                            state    <= ST_IDLE;
                        end
                    end
                endcase
            end
        end
    end

    // A clear coinciding with a press keeps only the new digit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_out <= 8'h00;
        end else if (key_valid) begin
            byte_out <= byte_clr ? {4'h0, key_code}
                                 : {byte_out[3:0], key_code};
        end else if (byte_clr) begin
            byte_out <= 8'h00;
        end
    end

endmodule

// File: tb/tb_hex_keypad_scanner.sv
// Randomised and directed bench for hex_keypad_scanner with a
// scan-level reference model of the keypad, debounce and byte shifter.
module tb_hex_keypad_scanner;

    localparam int DB = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] row_in;
    logic [3:0] col_out;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;
    logic       byte_clr;
    logic [7:0] byte_out;

    logic [15:0] keys;
    logic [15:0] win_mask [16];
    logic        clr_pulse;

    int          errors = 0;
    int          checks = 0;

    int          m_prev;
    int          m_cnt;
    bit          m_held;
    logic [3:0]  m_code;
    logic [7:0]  m_byte;

    always #5 clk = ~clk;

    hex_keypad_scanner #(
        .SCAN_DIV      (4),
        .DEBOUNCE_SCANS(DB)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .row_in   (row_in),
        .col_out  (col_out),
        .key_code (key_code),
        .key_valid(key_valid),
        .key_held (key_held),
        .byte_clr (byte_clr),
        .byte_out (byte_out)
    );

    // Passive matrix: a pressed key shorts its row to its column.
    always_comb begin
        row_in = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (keys[4*r+c] && !col_out[c]) begin
                    row_in[r] = 1'b0;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_prev = -1;
        m_cnt  = 0;
        m_held = 1'b0;
        m_code = 4'h0;
        m_byte = 8'h00;
    endtask

    // One full 16-cycle scan window, aligned to the column-0 start.
    task automatic run_scan();
        int         pulses;
        int         nk;
        int         first;
        int         res;
        bit         exp_pulse;
        logic [3:0] ecol;
        pulses = 0;
        for (int j = 0; j < 16; j++) begin
            keys = win_mask[j];
            @(negedge clk);
            if (j == 0) begin
                byte_clr = 1'b0;
                chk("byte_out", byte_out, m_byte);
            end
            ecol = 4'hF;
            ecol[((j + 1) / 4) % 4] = 1'b0;
            chk("col_out", col_out, ecol);
            if (key_valid) begin
                pulses++;
                if (clr_pulse) byte_clr = 1'b1;
            end
        end
        nk    = 0;
        first = 0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                if (win_mask[4*c+1][4*r+c]) begin
                    if (nk == 0) first = 4 * r + c;
                    nk++;
                end
            end
        end
        res = (nk == 0) ? -1 : (nk == 1) ? first : 16;
        if (res == m_prev) m_cnt = (m_cnt >= DB) ? DB : m_cnt + 1;
        else m_cnt = 1;
        m_prev    = res;
        exp_pulse = 1'b0;
        if (m_cnt == DB) begin
            if (!m_held && res >= 0 && res < 16) begin
                exp_pulse = 1'b1;
                m_code    = 4'(res);
                m_held    = 1'b1;
            end else if (m_held && res == -1) begin
                m_held = 1'b0;
            end
        end
        chk("pulses", pulses, {31'd0, exp_pulse});
        chk("key_code", key_code, m_code);
        chk("key_held", key_held, m_held);
        if (exp_pulse) begin
            m_byte = clr_pulse ? {4'h0, m_code} : {m_byte[3:0], m_code};
        end
    endtask

    task automatic scans(input logic [15:0] mask, input int n);
        for (int j = 0; j < 16; j++) win_mask[j] = mask;
        repeat (n) run_scan();
    endtask

    task automatic bounce(input int nwin);
        int t = 0;
        repeat (nwin) begin
            for (int j = 0; j < 16; j++) begin
                win_mask[j] = ((t / 10) % 2 == 0) ? 16'h0020 : 16'h0000;
                t++;
            end
            run_scan();
        end
    endtask

    function automatic logic [15:0] rand_mask();
        int sel;
        sel = $urandom_range(0, 99);
        if (sel < 40) return 16'h0000;
        if (sel < 85) return 16'h0001 << $urandom_range(0, 15);
        return (16'h0001 << $urandom_range(0, 15))
             | (16'h0001 << $urandom_range(0, 15));
    endfunction

    logic [15:0] base;
    int          hold;
    int          w;
    bit          bouncy;

    initial begin
        rst_n     = 1'b0;
        keys      = 16'h0;
        byte_clr  = 1'b0;
        clr_pulse = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_col", col_out, 4'b1110);
        chk("rst_code", key_code, 4'h0);
        chk("rst_valid", key_valid, 1'b0);
        chk("rst_held", key_held, 1'b0);
        chk("rst_byte", byte_out, 8'h00);
        rst_n = 1'b1;

        scans(16'h0000, 13);
        scans(16'h0040, 3);
        chk("byte_06", byte_out, 8'h06);
        scans(16'h0000, 3);
        scans(16'h0400, 3);
        scans(16'h0000, 3);
        scans(16'h0008, 3);
        scans(16'h0000, 3);
        chk("byte_a3", byte_out, 8'hA3);

        bounce(13);
        scans(16'h0000, 3);
        scans(16'h0020, 3);
        chk("code_5", key_code, 4'h5);
        scans(16'h0000, 3);

        scans(16'h8001, 7);
        chk("multi_held", key_held, 1'b0);
        scans(16'h0001, 3);
        chk("code_0", key_code, 4'h0);
        scans(16'h0000, 3);

        scans(16'h0010, 3);
        scans(16'h0000, 3);
        scans(16'h1000, 3);
        scans(16'h0000, 3);
        chk("byte_4c", byte_out, 8'h4C);
        clr_pulse = 1'b1;
        scans(16'h0200, 3);
        clr_pulse = 1'b0;
        scans(16'h0000, 3);
        chk("byte_09", byte_out, 8'h09);

        scans(16'h0080, 3);
        chk("held_pre_rst", key_held, 1'b1);
        keys = 16'h0080;
        repeat (5) @(negedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("mid_rst_col", col_out, 4'b1110);
        chk("mid_rst_code", key_code, 4'h0);
        chk("mid_rst_valid", key_valid, 1'b0);
        chk("mid_rst_held", key_held, 1'b0);
        chk("mid_rst_byte", byte_out, 8'h00);
        @(negedge clk);
        keys  = 16'h0;
        rst_n = 1'b1;
        model_reset();

        w = 0;
        while (w < 60) begin
            base = rand_mask();
            hold = $urandom_range(1, 4);
            for (int h = 0; h < hold; h++) begin
                bouncy = ($urandom_range(0, 4) == 0);
                for (int j = 0; j < 16; j++) begin
                    win_mask[j] = (bouncy && $urandom_range(0, 1) == 1)
                                ? 16'h0000 : base;
                end
                run_scan();
                w++;
            end
        end
        @(negedge clk);
        byte_clr = 1'b0;
        chk("byte_final", byte_out, m_byte);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
